// File: rtl/regfile_dump_tx_if.sv
// Byte stream with valid/ready handshake between the register dump
// streamer (master) and its sink, normally the UART transmitter (slave).
interface regfile_dump_tx_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_tx.sv
// Snapshots the flat register-file dump bus and streams it byte by byte,
// register 0 MSB byte first, followed by an XOR checksum byte.
module regfile_dump_tx #(
  parameter int NB_REG  = 32,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [NB_REG*N_REGS-1:0] i_registers,
  regfile_dump_tx_if.master        tx_if,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int NB_ALL  = NB_REG * N_REGS;
  localparam int N_BYTES = NB_ALL / NB_BYTE;
  localparam int NB_CNT  = $clog2(N_BYTES);

  typedef enum logic [1:0] {IDLE, SEND, CHKSUM, DONE} state_t;

  state_t              r_state,   w_state_nxt;
  logic [NB_CNT-1:0]   r_cnt,     w_cnt_nxt;
  logic [NB_BYTE-1:0]  r_chk,     w_chk_nxt;
  logic [NB_ALL-1:0]   r_snap,    w_snap_nxt;
  logic [NB_BYTE-1:0]  r_tx_data, w_tx_data_nxt;
  logic                r_tx_valid, w_tx_valid_nxt;

  logic w_accept;
  logic w_last;

  assign w_accept = r_tx_valid & tx_if.tx_ready;
  assign w_last   = (r_cnt == NB_CNT'(N_BYTES - 1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_chk      <= '0;
      r_snap     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_chk      <= w_chk_nxt;
      r_snap     <= w_snap_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  // The snapshot shifts left on every accept so the next byte always sits
  // just below the top byte; the first SEND cycle only loads the output.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_chk_nxt      = r_chk;
    w_snap_nxt     = r_snap;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_snap_nxt  = i_registers;
          w_cnt_nxt   = '0;
          w_chk_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (!r_tx_valid) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = r_snap[NB_ALL-1 -: NB_BYTE];
        end else if (w_accept) begin
          w_chk_nxt = r_chk ^ r_tx_data;
          if (w_last) begin
            w_tx_data_nxt = r_chk ^ r_tx_data;
            w_state_nxt   = CHKSUM;
          end else begin
            w_cnt_nxt     = r_cnt + 1'b1;
            w_snap_nxt    = r_snap << NB_BYTE;
            w_tx_data_nxt = r_snap[NB_ALL-NB_BYTE-1 -: NB_BYTE];
          end
        end
      end
      CHKSUM: begin
        if (w_accept) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign tx_if.tx_data  = r_tx_data;
  assign tx_if.tx_valid = r_tx_valid;
  assign o_busy         = (r_state != IDLE);
  assign o_done         = (r_state == DONE);
endmodule

// File: tb/tb_regfile_dump_tx.sv
// Randomized self-checking bench for regfile_dump_tx: a byte-list model of
// the dump is compared against the bytes the sink accepts.
module tb_regfile_dump_tx;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1023:0] regs_bus;
  logic          busy, done;

  regfile_dump_tx_if #(.NB_BYTE(8)) tx_if ();

  regfile_dump_tx #(.NB_REG(32), .N_REGS(32), .NB_BYTE(8)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_registers(regs_bus),
    .tx_if(tx_if.master), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          rdy_pct = 100;
  int          viol = 0;
  logic [7:0]  cap[$];
  logic [7:0]  expq[$];
  logic [31:0] model_regs[32];

  // Sink: ready changes just after each rising edge.
  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_if.tx_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Records accepted bytes and flags data/valid changing while stalled.
  initial begin
    logic       pv, pr;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== pd)) viol++;
        if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) cap.push_back(tx_if.tx_data);
        pv = tx_if.tx_valid;
        pr = tx_if.tx_ready;
        pd = tx_if.tx_data;
      end
    end
  end

  // Reference: bytes in register order, MSB byte first, then XOR of them all.
  task automatic load_regs();
    logic [1023:0] b;
    logic [7:0]    x, by;
    b = '0; x = '0;
    expq.delete();
    for (int k = 0; k < 32; k++) begin
      b = {b[991:0], model_regs[k]};
      for (int j = 0; j < 4; j++) begin
        by = 8'(model_regs[k] >> (24 - 8 * j));
        expq.push_back(by);
        x ^= by;
      end
    end
    expq.push_back(x);
    regs_bus = b;
  endtask

  function automatic int stream_errs();
    int e = 0;
    if (cap.size() != expq.size()) return 1000 + cap.size();
    foreach (cap[i]) if (cap[i] !== expq[i]) e++;
    return e;
  endfunction

  task automatic set_ordered();
    for (int k = 0; k < 32; k++)
      model_regs[k] = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    load_regs();
  endtask

  // Starts a dump at the next edge (N); k counts edges after N.
  task automatic run_dump(input bit mid_act, input bit hold_start,
                          output int fv, output int dk, output int ik, output int dcnt);
    cap.delete(); viol = 0;
    fv = -1; dk = -1; ik = -1; dcnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (mid_act && k == 20) begin regs_bus = '1; start = 1'b1; end
      if (mid_act && k == 23) start = 1'b0;
      if (tx_if.tx_valid === 1'b1 && fv < 0) fv = k;
      if (done === 1'b1) begin dcnt++; dk = k; end
      if (busy !== 1'b1) begin ik = k; break; end
    end
    checks++;
    if (ik < 0) begin failures++; $display("FAIL dump_timeout: busy still high after 3000 cycles, required low"); end
  endtask

  task automatic check_timing(input string nm, input int fv, input int dk, input int ik, input int dcnt);
    checks++;
    if (fv !== 1 || dk !== 130 || ik !== 131 || dcnt !== 1) begin
      failures++;
      $display("FAIL %s_timing: first_valid=%0d done=%0d idle=%0d pulses=%0d, required 1 130 131 1",
               nm, fv, dk, ik, dcnt);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (tx_if.tx_valid !== 1'b0 || tx_if.tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b, required 0 00 0 0",
               tx_if.tx_valid, tx_if.tx_data, busy, done);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", tx_if.tx_valid, busy);
    end
  endtask

  task automatic test_ordered();
    int fv, dk, ik, dc, e;
    rdy_pct = 100;
    set_ordered();
    run_dump(1'b0, 1'b0, fv, dk, ik, dc);
    check_timing("ordered", fv, dk, ik, dc);
    e = stream_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL ordered_stream: %0d byte errors (%0d bytes), required 0 (129)", e, cap.size()); end
    checks++;
    if (cap.size() != 129 || cap[0] !== 8'h00 || cap[127] !== 8'h7F || cap[128] !== 8'h00) begin
      failures++; $display("FAIL ordered_const: size=%0d last_data=%h chk=%h, required 129 7f 00",
                           cap.size(), cap[127], cap[128]);
    end
  endtask

  task automatic test_checksum();
    int fv, dk, ik, dc, e;
    rdy_pct = 100;
    for (int k = 0; k < 32; k++) model_regs[k] = '0;
    model_regs[31] = 32'hDEADBEEF;
    load_regs();
    @(posedge clk); #1;
    run_dump(1'b0, 1'b0, fv, dk, ik, dc);
    check_timing("checksum", fv, dk, ik, dc);
    e = stream_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL checksum_stream: %0d byte errors, required 0", e); end
    checks++;
    if (cap.size() != 129 || cap[124] !== 8'hDE || cap[127] !== 8'hEF || cap[128] !== 8'h22) begin
      failures++; $display("FAIL checksum_byte: got %h, required 22", cap[128]);
    end
  endtask

  task automatic test_backpressure();
    int fv, dk, ik, dc, e;
    rdy_pct = 40;
    set_ordered();
    @(posedge clk); #1;
    run_dump(1'b0, 1'b0, fv, dk, ik, dc);
    e = stream_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL bp_stream: %0d byte errors, required 0", e); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL bp_stable: %0d changes while stalled, required 0", viol); end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL bp_done: %0d pulses, required 1", dc); end
    rdy_pct = 100;
  endtask

  task automatic test_snapshot();
    int fv, dk, ik, dc, e, late;
    rdy_pct = 100;
    for (int k = 0; k < 32; k++) model_regs[k] = $urandom;
    load_regs();
    @(posedge clk); #1;
    run_dump(1'b1, 1'b0, fv, dk, ik, dc);
    check_timing("snapshot", fv, dk, ik, dc);
    e = stream_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL snapshot_stream: %0d byte errors, required 0", e); end
    late = 0;
    repeat (6) begin @(negedge clk); if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) late++; end
    checks++;
    if (late !== 0) begin failures++; $display("FAIL ignored_start: %0d busy cycles after done, required 0", late); end
  endtask

  task automatic test_reset_mid();
    int fv, dk, ik, dc, e, t;
    rdy_pct = 100;
    for (int k = 0; k < 32; k++) model_regs[k] = $urandom;
    load_regs();
    cap.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (cap.size() < 40 && t < 500) begin @(negedge clk); t++; end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cap.size() != 40 || tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_if.tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: accepted=%0d valid=%b busy=%b done=%b data=%h, required 40 0 0 0 00",
               cap.size(), tx_if.tx_valid, busy, done, tx_if.tx_data);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 32; k++) model_regs[k] = $urandom;
    load_regs();
    @(posedge clk); #1;
    run_dump(1'b0, 1'b0, fv, dk, ik, dc);
    check_timing("restart", fv, dk, ik, dc);
    e = stream_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL restart_stream: %0d byte errors, required 0", e); end
  endtask

  // With start held, the DONE cycle is followed by one IDLE cycle and one
  // load cycle, so the next valid appears three edges after the done edge.
  task automatic test_back_to_back();
    int fv, dk, ik, dc, e, t;
    rdy_pct = 100;
    set_ordered();
    @(posedge clk); #1;
    run_dump(1'b0, 1'b1, fv, dk, ik, dc);
    check_timing("b2b_first", fv, dk, ik, dc);
    @(negedge clk);
    cap.delete();
    checks++;
    if (busy !== 1'b1 || tx_if.tx_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_restart: busy=%b valid=%b at done+2, required 1 0", busy, tx_if.tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_if.tx_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_first_valid: valid=%b at done+3, required 1", tx_if.tx_valid);
    end
    start = 1'b0;
    t = 0;
    while (busy === 1'b1 && t < 500) begin @(negedge clk); t++; end
    e = stream_errs();
    checks++;
    if (e !== 0 || t >= 500) begin failures++; $display("FAIL b2b_second_stream: %0d byte errors, cycles=%0d, required 0", e, t); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; regs_bus = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_ordered();
    test_checksum();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
